// File: rtl/rv_muldiv_unit_pkg.sv
// Shared types and sizing for the RV32M multiply/divide unit.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplies).
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH) + 1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } md_state_e;

  function automatic logic opIsRem(input md_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/rv_muldiv_unit_if.sv
// Issue/write-back bundle between the core datapath and the multiply/divide unit.
interface rv_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [4:0]       rd_in;
  logic             busy;
  logic             wb_we;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;

  modport master (
    output start, funct3, src_a, src_b, rd_in,
    input  busy, wb_we, wb_addr, wb_data
  );

  modport slave (
    input  start, funct3, src_a, src_b, rd_in,
    output busy, wb_we, wb_addr, wb_data
  );
endinterface

// File: rtl/rv_muldiv_unit_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_last
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_remSh;
  logic [WIDTH:0]   w_diff;

  // {hi,lo} is the product for multiplies and {remainder,quotient} for divides
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_remSh = {r_hi, r_lo[WIDTH-1]};
    w_diff  = w_remSh - {1'b0, r_opnd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_hi   <= '0;
      r_lo   <= i_lo;
      r_opnd <= i_opnd;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (i_isDiv) begin
        if (!w_diff[WIDTH]) begin
          r_hi <= w_diff[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_remSh[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/rv_muldiv_unit.sv
// RV32M multiply/divide unit: FSM, operand sign handling, fast paths and register-file write-back.
// Optional build macro: MULDIV_FAST_MUL_EN (multiplies complete in one cycle via a `*` product).
module rv_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  rv_muldiv_unit_if.slave bus
);

  md_state_e        r_state;
  md_state_e        w_nextState;
  md_op_e           r_op;
  logic [4:0]       r_rd;
  logic             r_negRes;
  logic             r_wbWe;
  logic [4:0]       r_wbAddr;
  logic [WIDTH-1:0] r_wbData;

  md_op_e           w_op;
  logic             w_isDiv;
  logic             w_aNeg;
  logic             w_bNeg;
  logic             w_divZero;
  logic             w_ovf;
  logic             w_fast;
  logic             w_accept;
  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;
  logic [WIDTH-1:0] w_fastResult;
  logic [WIDTH-1:0] w_fixResult;
  logic [WIDTH-1:0] w_coreHi;
  logic [WIDTH-1:0] w_coreLo;
  logic             w_coreLast;
  logic [2*WIDTH-1:0] w_prodFix;

  assign w_op     = md_op_e'(bus.funct3);
  assign w_isDiv  = bus.funct3[2];
  assign w_accept = (r_state == IDLE) && bus.start;

  // Signed operands are reduced to magnitudes; the core only ever sees unsigned values
  always_comb begin
    w_aNeg    = (w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.src_a[WIDTH-1];
    w_bNeg    = (w_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && bus.src_b[WIDTH-1];
    w_magA    = w_aNeg ? (~bus.src_a + 1'b1) : bus.src_a;
    w_magB    = w_bNeg ? (~bus.src_b + 1'b1) : bus.src_b;
    w_divZero = w_isDiv && (bus.src_b == '0);
    w_ovf     = (w_op inside {OP_DIV, OP_REM}) && (bus.src_a == {1'b1, {(WIDTH-1){1'b0}}})
                && (bus.src_b == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fastProd;
  assign w_fastProd = {{WIDTH{w_aNeg}}, bus.src_a} * {{WIDTH{w_bNeg}}, bus.src_b};
  assign w_fast     = w_divZero || w_ovf || !w_isDiv;
`else
  assign w_fast     = w_divZero || w_ovf;
`endif

  always_comb begin
    w_fastResult = '1;
    if (w_divZero) begin
      w_fastResult = opIsRem(w_op) ? bus.src_a : '1;
    end else if (w_ovf) begin
      w_fastResult = opIsRem(w_op) ? '0 : bus.src_a;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!w_isDiv) begin
      w_fastResult = (w_op == OP_MUL) ? w_fastProd[WIDTH-1:0] : w_fastProd[2*WIDTH-1:WIDTH];
    end
`endif
  end

  muldiv_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W ($clog2(WIDTH) + 1)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_step  (r_state == CALC),
    .i_isDiv (r_op[2]),
    .i_lo    (w_isDiv ? w_magA : w_magB),
    .i_opnd  (w_isDiv ? w_magB : w_magA),
    .o_hi    (w_coreHi),
    .o_lo    (w_coreLo),
    .o_last  (w_coreLast)
  );

  // Sign correction applies to the full double-width product so MULH* see correct upper bits
  always_comb begin
    w_prodFix = r_negRes ? (~{w_coreHi, w_coreLo} + 1'b1) : {w_coreHi, w_coreLo};
    case (r_op)
      OP_MUL:                      w_fixResult = w_prodFix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fixResult = w_prodFix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             w_fixResult = r_negRes ? (~w_coreLo + 1'b1) : w_coreLo;
      default:                     w_fixResult = r_negRes ? (~w_coreHi + 1'b1) : w_coreHi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = w_fast ? DONE : CALC;
      CALC:    if (w_coreLast) w_nextState = FIX;
      FIX:     w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Quotient sign is sa^sb, remainder follows the dividend
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_rd     <= '0;
      r_negRes <= 1'b0;
    end else if (w_accept) begin
      r_op     <= w_op;
      r_rd     <= bus.rd_in;
      r_negRes <= (w_op == OP_REM) ? w_aNeg : (w_aNeg ^ w_bNeg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbWe   <= 1'b0;
      r_wbAddr <= '0;
      r_wbData <= '0;
    end else begin
      r_wbWe <= 1'b0;
      if (w_accept && w_fast) begin
        r_wbWe   <= (bus.rd_in != 5'd0);
        r_wbAddr <= bus.rd_in;
        r_wbData <= w_fastResult;
      end else if (r_state == FIX) begin
        r_wbWe   <= (r_rd != 5'd0);
        r_wbAddr <= r_rd;
        r_wbData <= w_fixResult;
      end
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.wb_we   = r_wbWe;
  assign bus.wb_addr = r_wbAddr;
  assign bus.wb_data = r_wbData;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed self-checking bench for rv_muldiv_unit with a shadow register file on the write port.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_rv_muldiv_unit;

  localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int weCount = 0;
  logic [31:0] regFile [32] = '{default: 32'h0};

  rv_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  rv_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shadow register file: x0 is never written, every pulse is counted
  always @(posedge clk) begin
    if (bus.wb_we) begin
      weCount <= weCount + 1;
      if (bus.wb_addr != 5'd0) regFile[bus.wb_addr] <= bus.wb_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
    end
  endtask

  // Issues one op and follows it to completion; optionally re-pulses start mid-flight
  task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] expData, input bit fastOp, input int midStartAt);
    int lat, busyCnt, weBefore, weLat, expLat;
    logic [4:0] weAddr;
    logic [31:0] weData;
    expLat = fastOp ? 0 : WIDTH + 1;
    weLat = -1;
    weAddr = '0;
    weData = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.src_a = a;
    bus.src_b = b;
    bus.rd_in = rd;
    @(negedge clk);
    bus.start = 1'b0;
    weBefore = weCount;
    lat = 0;
    busyCnt = 0;
    while (bus.busy && lat < 200) begin
      if (bus.wb_we && weLat < 0) begin
        weLat = lat;
        weAddr = bus.wb_addr;
        weData = bus.wb_data;
      end
      busyCnt++;
      if (lat == midStartAt) begin
        bus.start = 1'b1;
        bus.funct3 = 3'b000;
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        bus.rd_in = 5'd4;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    checkOutput({tag, "_busyCycles"}, 32'(busyCnt), 32'(expLat + 1));
    checkOutput({tag, "_wePulses"}, 32'(weCount - weBefore), (rd != 5'd0) ? 32'd1 : 32'd0);
    if (rd != 5'd0) begin
      checkOutput({tag, "_latency"}, 32'(weLat), 32'(expLat));
      checkOutput({tag, "_addr"}, {27'd0, weAddr}, {27'd0, rd});
      checkOutput({tag, "_data"}, weData, expData);
      checkOutput({tag, "_regFile"}, regFile[rd], expData);
    end
    @(negedge clk);
    checkOutput({tag, "_idleAfter"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int weBefore;
    bus.start = 1'b0;
    bus.funct3 = 3'b000;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.rd_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_we", 32'(bus.wb_we), 32'd0);
    checkOutput("reset_addr", {27'd0, bus.wb_addr}, 32'd0);
    checkOutput("reset_data", bus.wb_data, 32'd0);

    applyStimulus("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, FAST_MUL, -1);
    applyStimulus("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, FAST_MUL, -1);
    applyStimulus("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 5'd7, 32'hFFFFFFFF, FAST_MUL, -1);
    applyStimulus("mulh", 3'b001, 32'h80000000, 32'h80000000, 5'd8, 32'h40000000, FAST_MUL, -1);

    applyStimulus("div", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 1'b0, -1);
    applyStimulus("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 1'b0, -1);
    applyStimulus("divu", 3'b101, 32'd100, 32'd7, 5'd11, 32'h0000000E, 1'b0, -1);
    applyStimulus("remu", 3'b111, 32'd100, 32'd7, 5'd12, 32'h00000002, 1'b0, -1);

    applyStimulus("divuZero", 3'b101, 32'h1234, 32'd0, 5'd13, 32'hFFFFFFFF, 1'b1, -1);
    applyStimulus("remZero", 3'b110, 32'h1234, 32'd0, 5'd14, 32'h00001234, 1'b1, -1);
    applyStimulus("divOvf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1, -1);
    applyStimulus("remOvf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1'b1, -1);

    applyStimulus("busyStart", 3'b101, 32'd100, 32'd7, 5'd3, 32'h0000000E, 1'b0, 5);
    checkOutput("busyStart_x4Untouched", regFile[4], 32'd0);
    applyStimulus("rdZero", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd0, 32'h0, FAST_MUL, -1);

    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'b101;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    bus.rd_in = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    weBefore = weCount;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_we", 32'(bus.wb_we), 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("abort_noWrite", 32'(weCount - weBefore), 32'd0);
    checkOutput("abort_x20", regFile[20], 32'd0);
    applyStimulus("mulAfterAbort", 3'b000, 32'd3, 32'd4, 5'd21, 32'h0000000C, FAST_MUL, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
